aes_mixcol_engine: RTL
======================

// Module: aes_mixcol_engine
// PURPOSE
//   Sequential AES MixColumns / InvMixColumns engine over a 128-bit state.
//   Generalises the fixed per-byte GF(2^8) constant multipliers into a full column transform.
//   Runtime mode select: forward (coefficients 02,03,01,01) or inverse (0e,0b,0d,09).
//   Configurable column parallelism. Sits between ShiftRows and AddRoundKey in the round datapath.
// PARAMETERS
//   COLS_PER_CYCLE  1  columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error
//   PASSES          4/COLS_PER_CYCLE  localparam; number of busy cycles per block
// PORTS
//   clk        in   1    single clock; all state updates on the rising edge
//   rst        in   1    synchronous, active-high reset
//   in_valid   in   1    input block present
//   in_ready   out  1    engine can accept a block this cycle
//   in_state   in   128  input state; column c = [127-32c -: 32], row 0 in the MSB byte
//   in_inv     in   1    0 = MixColumns, 1 = InvMixColumns; sampled with the block
//   in_skip    in   1    only with MIXCOL_SKIP_EN: pass the block through unchanged
//   out_valid  out  1    result block present
//   out_ready  in   1    downstream accepts the result
//   out_state  out  128  transformed state, same byte layout as in_state
//   busy       out  1    high in the BUSY state
// BEHAVIOUR
//   Reset: out_valid=0, in_ready=0 during reset, busy=0, out_state=0, FSM=IDLE, col_cnt=0.
//   Handshake: a transfer occurs when valid && ready on the same edge; in_ready = IDLE || (DONE && out_ready).
//   FSM:
//     IDLE -accept-> BUSY: latch in_state, in_inv; col_cnt=0.
//     BUSY: each cycle, transform COLS_PER_CYCLE columns starting at col_cnt and write them in place.
//       col_cnt += COLS_PER_CYCLE; on the last pass go to DONE.
//     DONE: out_valid=1; out_state is held stable until out_ready.
//       out_ready && !in_valid -> IDLE.
//       out_ready && in_valid -> accept the new block and go directly to BUSY (back-to-back).
//   Latency: accept to out_valid = PASSES cycles (4, 2, or 1).
//     Sustained throughput: one block per PASSES+1 cycles.
//   Arithmetic: GF(2^8) mod x^8+x^4+x^3+x+1. xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
//     The 09/0b/0d/0e products are built from xtime chains; no 256-entry tables.
//     out[r] = XOR over k of coef[(k-r) mod 4] * a[k].
//   Mode is per-block; changing in_inv while BUSY has no effect until the next accept.
//   in_valid while BUSY is ignored (in_ready=0); the input must be held by the source.
//   Reset asserted mid-operation aborts the block, returns to IDLE and drops out_valid the next cycle.
// CONFIGURATION
//   MIXCOL_SKIP_EN defined: in_skip is present and latched at accept.
//     If it is set, the FSM goes IDLE->DONE with out_state = in_state (latency 1), ignoring in_inv.
//     This serves the final AES round.
//   MIXCOL_SKIP_EN undefined: the in_skip port does not exist; every block is transformed.
// STRUCTURE
//   Package aes_pkg:
//     typedef state_t [127:0], col_t [31:0], byte_t [7:0]
//     localparam GF_POLY = 8'h1B
//     FSM state enum {IDLE, BUSY, DONE}
//     function xtime()
//   Sub-module aes_mixcol_column: one combinational 32-bit column transform with an inv input.
//     Instantiate it COLS_PER_CYCLE times via generate.
//   The top level holds the FSM, col_cnt, state register and handshake.
// TESTING
//   1. Forward, C=1:
//      db135345_f20a225c_01010101_c6c6c6c6 -> 8e4da1bc_9fdc589d_01010101_c6c6c6c6.
//      out_valid rises exactly 4 cycles after accept.
//   2. Inverse, C=4: input 8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> db135345_f20a225c_01010101_c6c6c6c6.
//      Latency is 1 cycle.
//   3. Back-to-back, C=2: hold out_ready=1 and in_valid=1 for 3 blocks.
//      A new accept occurs on each DONE cycle. Results match the reference model in order.
//      in_ready is never high while BUSY.
//   4. Backpressure: hold out_ready=0 for 10 cycles in DONE.
//      out_state is stable and in_ready=0. Toggling in_inv and in_state has no effect on the result.
//   5. Reset after 2 BUSY cycles (C=1): the next cycle shows out_valid=0, busy=0.
//      A fresh block then completes correctly.
//   6. MIXCOL_SKIP_EN with in_skip=1, in_state=d4d4d4d5_2d26314c_00000000_ffffffff:
//      out_state is identical and out_valid follows 1 cycle after accept.
//      With in_skip=0, word 0 gives d5d5d7d6 and word 1 gives 4d7ebdf8.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types, GF(2^8) reduction constant, FSM encoding and xtime helper
// for the AES MixColumns engine.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;
  typedef logic [7:0]   byte_t;

  localparam byte_t GF_POLY = 8'h1B;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_state_e;

  // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mixcol_column.sv
// Combinational transform of one 32-bit column: MixColumns when i_inv=0,
// InvMixColumns when i_inv=1. Row 0 sits in the most significant byte.
module aes_mixcol_column
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  input  logic        i_inv,
  output logic [31:0] o_col
);

  byte_t w_a  [4];
  byte_t w_x2 [4];
  byte_t w_x4 [4];
  byte_t w_x8 [4];
  byte_t w_m3 [4];
  byte_t w_m9 [4];
  byte_t w_mb [4];
  byte_t w_md [4];
  byte_t w_me [4];
  byte_t w_fwd[4];
  byte_t w_rev[4];

  // All constant products come from one xtime chain per byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_prod
    assign w_a[gi]  = i_col[31-8*gi -: 8];
    assign w_x2[gi] = xtime(w_a[gi]);
    assign w_x4[gi] = xtime(w_x2[gi]);
    assign w_x8[gi] = xtime(w_x4[gi]);
    assign w_m3[gi] = w_x2[gi] ^ w_a[gi];
    assign w_m9[gi] = w_x8[gi] ^ w_a[gi];
    assign w_mb[gi] = w_x8[gi] ^ w_x2[gi] ^ w_a[gi];
    assign w_md[gi] = w_x8[gi] ^ w_x4[gi] ^ w_a[gi];
    assign w_me[gi] = w_x8[gi] ^ w_x4[gi] ^ w_x2[gi];
  end

  // Row r takes coefficient (k-r) mod 4 for input row k.
  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    localparam int K1 = (gi + 1) % 4;
    localparam int K2 = (gi + 2) % 4;
    localparam int K3 = (gi + 3) % 4;
    assign w_fwd[gi] = w_x2[gi] ^ w_m3[K1] ^ w_a[K2]  ^ w_a[K3];
    assign w_rev[gi] = w_me[gi] ^ w_mb[K1] ^ w_md[K2] ^ w_m9[K3];
    assign o_col[31-8*gi -: 8] = i_inv ? w_rev[gi] : w_fwd[gi];
  end

endmodule

// File: rtl/aes_mixcol_engine.sv
// Sequential MixColumns/InvMixColumns engine: COLS_PER_CYCLE columns per clock,
// valid/ready on both sides. Optional pass-through enabled by MIXCOL_SKIP_EN.
module aes_mixcol_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
`ifdef MIXCOL_SKIP_EN
  input  logic         in_skip,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         PASSES   = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  fsm_state_e r_fsm, w_fsm_next;
  state_t     r_state, w_upd;
  logic       r_inv;
  logic [1:0] r_col_cnt;
  logic       w_accept, w_last;
  fsm_state_e w_start;

  logic [1:0]  w_idx    [COLS_PER_CYCLE];
  logic [31:0] w_col_in [COLS_PER_CYCLE];
  logic [31:0] w_col_out[COLS_PER_CYCLE];

`ifdef MIXCOL_SKIP_EN
  assign w_start = in_skip ? DONE : BUSY;
`else
  assign w_start = BUSY;
`endif

  assign w_last = (r_col_cnt == LAST_CNT);

  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
    assign w_idx[gi]    = r_col_cnt + 2'(gi);
    assign w_col_in[gi] = r_state[(3 - int'(w_idx[gi]))*32 +: 32];
    aes_mixcol_column u_col (
      .i_col (w_col_in[gi]),
      .i_inv (r_inv),
      .o_col (w_col_out[gi])
    );
  end

  always_comb begin
    w_upd = r_state;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      w_upd[(3 - int'(w_idx[k]))*32 +: 32] = w_col_out[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_next;
  end

  always_comb begin
    w_fsm_next = r_fsm;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (r_fsm)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) w_fsm_next = w_start;
      end
      BUSY: begin
        busy = 1'b1;
        if (w_last) w_fsm_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready && !rst;
        // A waiting source is taken on the same edge the result leaves.
        if (out_ready) w_fsm_next = in_valid ? w_start : IDLE;
      end
      default: w_fsm_next = IDLE;
    endcase
    w_accept = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= '0;
      r_inv     <= 1'b0;
      r_col_cnt <= '0;
    end else if (w_accept) begin
      r_state   <= in_state;
      r_inv     <= in_inv;
      r_col_cnt <= '0;
    end else if (r_fsm == BUSY) begin
      r_state   <= w_upd;
      r_col_cnt <= r_col_cnt + COL_STEP;
    end
  end

  assign out_state = r_state;

endmodule
